br_tag_alloc: RTL and testbench
===============================

// Module: br_tag_alloc
// PURPOSE
//  Allocates and recycles the circular branch tags (brmask) carried by every ROB/issue entry.
//  - Per dispatch group: gives each branch a new tag and gives each instruction its mask.
//  - On a mispredict: emits the kill vector {enkill, brmask} that ROB banks and slots consume.
//  - Frees resolved tags oldest-first.
//  - Sits between decode/dispatch and the ROB. Its kill output drives the ROB i_kill port.
// PARAMETERS
//  WIDTH_BRM  4  tag/mask width. At most 2^WIDTH_BRM-1 branches outstanding, so wrap compare is unambiguous.
//  NDIS       4  dispatch group width; fixed at 4 to match the 4-bank ROB.
// PORTS
//  i_clk          in   1            clock; all state updates on posedge.
//  i_rst          in   1            synchronous, active-high reset.
//  i_dis_we       in   1            dispatch group valid this cycle.
//  i_dis_br4x     in   4            bit k set: slot k is a branch needing a tag.
//  o_dis_mask4x   out  4*WIDTH_BRM  mask for slot k at [(k+1)*W-1:k*W]; combinational.
//  o_dis_tag4x    out  4*WIDTH_BRM  tag allocated to branch slot k; don't-care for non-branch slots.
//  o_stall        out  1            group cannot be accepted this cycle; combinational.
//  i_res_en       in   1            branch resolution valid.
//  i_res_tag      in   WIDTH_BRM    tag of the resolving branch.
//  i_res_mispred  in   1            resolution was a mispredict.
//  o_kill         out  WIDTH_BRM+1  {enkill, kill_mask}; registered, valid one cycle.
//  o_free         out  WIDTH_BRM+1  {en, tag} of the tag recycled this cycle; registered.
//  o_cnt          out  WIDTH_BRM    number of outstanding tags.
// BEHAVIOUR
//  State
//   - r_tail: last allocated tag, i.e. the current mask.
//   - r_head: oldest outstanding tag.
//   - r_cnt:  number of outstanding tags.
//   - r_done: resolved bitmap, 2^W bits.
//   - r_st:   RUN or KILL.
//  Reset (i_rst sampled at posedge; overrides everything, including mid-KILL)
//   - r_tail=0, r_head=1, r_cnt=0, r_done=0, r_st=RUN.
//   - o_kill=0, o_free=0, o_cnt=0.
//  Mask and tag assignment, n = popcount(i_dis_br4x)
//   - Branch in slot k gets tag = r_tail + (number of branches in slots <= k).
//   - Slot k mask = r_tail + (number of branches in slots < k), so a branch carries its predecessor's mask.
//   - All arithmetic is mod 2^W; 15+1 wraps to 0.
//  Stall
//   - o_stall = i_dis_we & (r_st==KILL | (i_res_en & i_res_mispred) | r_cnt + n > 2^W-1).
//   - A stalled group allocates nothing; the group is all-or-nothing.
//  Accept (i_dis_we & ~o_stall)
//   - r_tail += n; r_cnt += n; r_done bits for the new tags are cleared.
//  Correct resolution (i_res_en & ~i_res_mispred)
//   - Sets r_done[i_res_tag] if the tag is outstanding, i.e. within [r_head, r_tail] circularly with r_cnt != 0.
//   - Otherwise ignored (stale after a kill).
//  Freeing
//   - At most 1 tag per cycle: if r_cnt != 0 and r_done[r_head]:
//     o_free <= {1, r_head}; r_head++; r_cnt--; r_done[r_head] cleared.
//   - Otherwise o_free <= 0.
//   - Freeing uses r_done as registered at cycle start, so a tag resolved in cycle c frees in cycle c+1 at the earliest.
//  Mispredict (i_res_en & i_res_mispred, tag outstanding, r_st==RUN)
//   - o_kill <= {1, i_res_tag-1}: slots with mask in (tag-1, old r_tail] die.
//   - r_tail <= i_res_tag-1; r_done for killed tags cleared.
//   - r_cnt <= distance(r_head, tag-1)+1, after any same-cycle free.
//   - r_st <= KILL.
//   - Mispredict of the head tag leaves r_cnt=0.
//   - A mispredict of a non-outstanding tag is ignored.
//  KILL
//   - Lasts exactly 1 cycle; o_kill valid; dispatch stalled; resolutions accepted.
//   - Then r_st <= RUN and o_kill <= 0.
//  Precedence: a mispredict arriving while r_st==KILL is ignored (younger branches already killed).
//  Latency: mask/tag/stall 0 cycles; kill 1 cycle after mispredict; free >= 1 cycle after resolve.
//  Simultaneous events
//   - Accept and free in the same cycle: r_cnt += n-1.
//   - Accept is never simultaneous with a mispredict (stall).
//  Invariant: r_tail == r_head + r_cnt - 1 (mod 2^W) at all times.
// TESTING
//  1. Reset, dispatch br4x=0101 -> masks {0,1,1,2}, tags slot0=1 slot2=2, r_tail=2, o_cnt=2, o_stall=0.
//  2. 14 outstanding, dispatch br4x=0011 -> o_stall=1, tail/cnt unchanged; with br4x=0001 -> accepted, o_cnt=15.
//  3. Tags 1..3 outstanding, mispredict tag 2 -> next cycle o_kill=5'b1_0001, o_cnt=1, dispatch stalled that cycle; following cycle o_kill=0, o_stall=0.
//  4. Tags 1,2 outstanding, resolve 2 then 1 -> no free after 2; then o_free={1,1}, next cycle o_free={1,2}, o_cnt=0.
//  5. Wrap: r_tail=13, dispatch br4x=1111 -> tags 14,15,0,1; mispredict tag 0 -> o_kill=5'b1_1111, r_tail=15.
//  6. i_rst asserted during the KILL cycle -> next cycle o_kill=0, o_cnt=0, r_tail=0; a stale resolution of tag 3 is ignored.

Source files
------------

// File: rtl/br_tag_alloc.sv
// Circular branch-tag allocator: hands out tags and masks per dispatch group,
// emits the kill vector on a mispredict and recycles resolved tags oldest-first.
module br_tag_alloc #(
    parameter int unsigned WIDTH_BRM = 4,
    parameter int unsigned NDIS      = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_dis_we,
    input  logic [NDIS-1:0]           i_dis_br4x,
    output logic [NDIS*WIDTH_BRM-1:0] o_dis_mask4x,
    output logic [NDIS*WIDTH_BRM-1:0] o_dis_tag4x,
    output logic                      o_stall,
    input  logic                      i_res_en,
    input  logic [WIDTH_BRM-1:0]      i_res_tag,
    input  logic                      i_res_mispred,
    output logic [WIDTH_BRM:0]        o_kill,
    output logic [WIDTH_BRM:0]        o_free,
    output logic [WIDTH_BRM-1:0]      o_cnt
);
    localparam int unsigned NTAG = 1 << WIDTH_BRM;
    localparam logic [WIDTH_BRM-1:0] TAG_ONE = WIDTH_BRM'(1);
    localparam logic [WIDTH_BRM:0] MAX_OUT = (WIDTH_BRM + 1)'(NTAG - 1);

    localparam logic ST_RUN  = 1'b0;
    localparam logic ST_KILL = 1'b1;

    logic [WIDTH_BRM-1:0] r_tail;
    logic [WIDTH_BRM-1:0] r_head;
    logic [WIDTH_BRM-1:0] r_cnt;
    logic [NTAG-1:0]      r_done;
    logic                 r_st;
    logic [WIDTH_BRM:0]   r_kill;
    logic [WIDTH_BRM:0]   r_free;

    logic [WIDTH_BRM-1:0] acc;
    logic [WIDTH_BRM-1:0] n_br;
    logic [WIDTH_BRM-1:0] res_dist;
    logic [WIDTH_BRM-1:0] kill_tail;
    logic [WIDTH_BRM-1:0] kill_span;
    logic [WIDTH_BRM-1:0] kill_off;
    logic                 res_out;
    logic                 set_en;
    logic                 kill_en;
    logic                 free_en;
    logic                 acc_en;
    logic                 cnt_full;

    logic [WIDTH_BRM-1:0] tail_d;
    logic [WIDTH_BRM-1:0] head_d;
    logic [WIDTH_BRM-1:0] cnt_d;
    logic [NTAG-1:0]      done_d;

    // Running tag: each slot's mask is the tag before its own increment.
    always_comb begin
        acc          = r_tail;
        o_dis_mask4x = '0;
        o_dis_tag4x  = '0;
        for (int k = 0; k < NDIS; k++) begin
            o_dis_mask4x[k*WIDTH_BRM +: WIDTH_BRM] = acc;
            if (i_dis_br4x[k]) begin
                acc = acc + TAG_ONE;
            end
            o_dis_tag4x[k*WIDTH_BRM +: WIDTH_BRM] = acc;
        end
        n_br = acc - r_tail;
    end

    always_comb begin
        res_dist  = i_res_tag - r_head;
        res_out   = (r_cnt != '0) && (res_dist < r_cnt);
        kill_en   = i_res_en & i_res_mispred & res_out & (r_st == ST_RUN);
        set_en    = i_res_en & ~i_res_mispred & res_out;
        kill_tail = i_res_tag - TAG_ONE;
        kill_span = r_tail - i_res_tag;
        cnt_full  = ({1'b0, r_cnt} + {1'b0, n_br}) > MAX_OUT;
        o_stall   = i_dis_we & ((r_st == ST_KILL) | (i_res_en & i_res_mispred) | cnt_full);
        acc_en    = i_dis_we & ~o_stall;
        // A done head being mispredicted is contradictory; the kill wins.
        free_en   = (r_cnt != '0) & r_done[r_head] & ~(kill_en & (res_dist == '0));
    end

    always_comb begin
        tail_d   = r_tail;
        head_d   = r_head;
        done_d   = r_done;
        kill_off = '0;
        cnt_d    = r_cnt - (free_en ? TAG_ONE : '0) + (acc_en ? n_br : '0);

        if (set_en) begin
            done_d[i_res_tag] = 1'b1;
        end
        if (free_en) begin
            head_d         = r_head + TAG_ONE;
            done_d[r_head] = 1'b0;
        end
        if (acc_en) begin
            tail_d = acc;
            for (int k = 0; k < NDIS; k++) begin
                if (i_dis_br4x[k]) begin
                    done_d[o_dis_tag4x[k*WIDTH_BRM +: WIDTH_BRM]] = 1'b0;
                end
            end
        end
        // Killed tags span [i_res_tag, r_tail] circularly.
        if (kill_en) begin
            tail_d = kill_tail;
            cnt_d  = i_res_tag - head_d;
            for (int t = 0; t < NTAG; t++) begin
                kill_off = WIDTH_BRM'(t) - i_res_tag;
                if (kill_off <= kill_span) begin
                    done_d[t] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tail <= '0;
            r_head <= TAG_ONE;
            r_cnt  <= '0;
            r_done <= '0;
            r_st   <= ST_RUN;
            r_kill <= '0;
            r_free <= '0;
        end else begin
            r_tail <= tail_d;
            r_head <= head_d;
            r_cnt  <= cnt_d;
            r_done <= done_d;
            r_st   <= kill_en ? ST_KILL : ST_RUN;
            r_kill <= kill_en ? {1'b1, kill_tail} : '0;
            r_free <= free_en ? {1'b1, r_head} : '0;
        end
    end

    assign o_kill = r_kill;
    assign o_free = r_free;
    assign o_cnt  = r_cnt;

endmodule

// File: tb/tb_br_tag_alloc.sv
// Bench for br_tag_alloc: directed scenarios plus random traffic against a
// queue-based model of outstanding branch tags.
module tb_br_tag_alloc;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dis_we = 1'b0;
    logic [3:0]  dis_br = '0;
    logic [15:0] dis_mask;
    logic [15:0] dis_tag;
    logic        stall;
    logic        res_en = 1'b0;
    logic [3:0]  res_tag = '0;
    logic        res_mis = 1'b0;
    logic [4:0]  kill;
    logic [4:0]  free;
    logic [3:0]  cnt;

    int errors = 0;
    int checks = 0;

    // Model: outstanding tags oldest-first with resolved flags.
    int         m_q[$];
    bit         m_d[$];
    int         m_last = 0;
    bit         m_kst = 1'b0;
    logic [4:0] m_kill = '0;
    logic [4:0] m_free = '0;

    br_tag_alloc #(.WIDTH_BRM(4), .NDIS(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_dis_we(dis_we), .i_dis_br4x(dis_br),
        .o_dis_mask4x(dis_mask), .o_dis_tag4x(dis_tag), .o_stall(stall),
        .i_res_en(res_en), .i_res_tag(res_tag), .i_res_mispred(res_mis),
        .o_kill(kill), .o_free(free), .o_cnt(cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] exp_masks(int last, logic [3:0] br);
        logic [15:0] r;
        logic [3:0]  below;
        for (int k = 0; k < 4; k++) begin
            below = 4'((1 << k) - 1);
            r[k*4 +: 4] = 4'((last + $countones(br & below)) % 16);
        end
        return r;
    endfunction

    function automatic logic [15:0] exp_tags(int last, logic [3:0] br);
        logic [15:0] r;
        logic [3:0]  upto;
        for (int k = 0; k < 4; k++) begin
            upto = 4'((2 << k) - 1);
            r[k*4 +: 4] = 4'((last + $countones(br & upto)) % 16);
        end
        return r;
    endfunction

    task automatic drive(input logic we, input logic [3:0] br, input logic ren,
                         input logic [3:0] rt, input logic rm);
        dis_we  = we;
        dis_br  = br;
        res_en  = ren;
        res_tag = rt;
        res_mis = rm;
        #1;
    endtask

    // Advance the model by one cycle from the current inputs, then clock the DUT.
    task automatic tick();
        int  n;
        int  found;
        bit  stall_m;
        bit  nk;
        n       = $countones(dis_br);
        stall_m = dis_we && (m_kst || (res_en && res_mis) || (m_q.size() + n > 15));
        m_free  = '0;
        m_kill  = '0;
        nk      = 1'b0;
        if (m_q.size() > 0 && m_d[0]) begin
            m_free = {1'b1, 4'(m_q[0])};
            void'(m_q.pop_front());
            void'(m_d.pop_front());
        end
        found = -1;
        foreach (m_q[i]) if (m_q[i] == int'(res_tag)) found = i;
        if (res_en && found >= 0) begin
            if (!res_mis) begin
                m_d[found] = 1'b1;
            end else if (!m_kst) begin
                while (m_q.size() > found) begin
                    void'(m_q.pop_back());
                    void'(m_d.pop_back());
                end
                m_last = (int'(res_tag) + 15) % 16;
                m_kill = {1'b1, 4'(m_last)};
                nk     = 1'b1;
            end
        end
        if (dis_we && !stall_m) begin
            for (int k = 0; k < 4; k++) begin
                if (dis_br[k]) begin
                    m_last = (m_last + 1) % 16;
                    m_q.push_back(m_last);
                    m_d.push_back(1'b0);
                end
            end
        end
        m_kst = nk;
        if (rst) begin
            m_q.delete();
            m_d.delete();
            m_last = 0;
            m_kst  = 1'b0;
            m_kill = '0;
            m_free = '0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 4'b0000, 1'b0, 4'd0, 1'b0);
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        drive(1'b0, 4'b0000, 1'b0, 4'd0, 1'b0);
        checks++; if (kill !== 5'd0) begin errors++; $display("FAIL reset_kill: got %h want 00", kill); end
        checks++; if (free !== 5'd0) begin errors++; $display("FAIL reset_free: got %h want 00", free); end
        checks++; if (cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", cnt); end
        checks++; if (dis_mask[3:0] !== 4'd0) begin errors++; $display("FAIL reset_tail: got %0d want 0", dis_mask[3:0]); end
    endtask

    task automatic test_dispatch();
        do_reset();
        drive(1'b1, 4'b0101, 1'b0, 4'd0, 1'b0);
        checks++; if (dis_mask !== 16'h2110) begin errors++; $display("FAIL disp_mask: got %h want 2110", dis_mask); end
        checks++; if (dis_tag[3:0] !== 4'd1 || dis_tag[11:8] !== 4'd2) begin
            errors++; $display("FAIL disp_tag: got %h want slot0=1 slot2=2", dis_tag); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL disp_stall: got %b want 0", stall); end
        tick();
        drive(1'b0, 4'b0000, 1'b0, 4'd0, 1'b0);
        checks++; if (cnt !== 4'd2) begin errors++; $display("FAIL disp_cnt: got %0d want 2", cnt); end
        checks++; if (dis_mask[3:0] !== 4'd2) begin errors++; $display("FAIL disp_tail: got %0d want 2", dis_mask[3:0]); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'b1111, 1'b0, 4'd0, 1'b0);
            tick();
        end
        drive(1'b1, 4'b0011, 1'b0, 4'd0, 1'b0);
        tick();
        drive(1'b1, 4'b0011, 1'b0, 4'd0, 1'b0);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL full_stall: got %b want 1", stall); end
        tick();
        drive(1'b1, 4'b0001, 1'b0, 4'd0, 1'b0);
        checks++; if (cnt !== 4'd14 || dis_mask[3:0] !== 4'd14) begin
            errors++; $display("FAIL full_hold: got cnt=%0d tail=%0d want 14 14", cnt, dis_mask[3:0]); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL full_fit: got %b want 0", stall); end
        tick();
        drive(1'b0, 4'b0000, 1'b0, 4'd0, 1'b0);
        checks++; if (cnt !== 4'd15) begin errors++; $display("FAIL full_cnt: got %0d want 15", cnt); end
    endtask

    task automatic test_mispredict();
        do_reset();
        drive(1'b1, 4'b0111, 1'b0, 4'd0, 1'b0);
        tick();
        drive(1'b1, 4'b0001, 1'b1, 4'd2, 1'b1);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL mis_same_stall: got %b want 1", stall); end
        tick();
        drive(1'b1, 4'b0001, 1'b0, 4'd0, 1'b0);
        checks++; if (kill !== 5'b1_0001) begin errors++; $display("FAIL mis_kill: got %b want 10001", kill); end
        checks++; if (cnt !== 4'd1) begin errors++; $display("FAIL mis_cnt: got %0d want 1", cnt); end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL mis_kill_stall: got %b want 1", stall); end
        tick();
        checks++; if (kill !== 5'd0) begin errors++; $display("FAIL mis_kill_clr: got %b want 00000", kill); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mis_run_stall: got %b want 0", stall); end
        drive(1'b0, 4'b0000, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic test_free_order();
        do_reset();
        drive(1'b1, 4'b0011, 1'b0, 4'd0, 1'b0);
        tick();
        drive(1'b0, 4'b0000, 1'b1, 4'd2, 1'b0);
        tick();
        drive(1'b0, 4'b0000, 1'b1, 4'd1, 1'b0);
        checks++; if (free !== 5'd0) begin errors++; $display("FAIL free_young: got %h want 00", free); end
        tick();
        drive(1'b0, 4'b0000, 1'b0, 4'd0, 1'b0);
        checks++; if (free !== 5'd0) begin errors++; $display("FAIL free_latency: got %h want 00", free); end
        tick();
        checks++; if (free !== 5'h11) begin errors++; $display("FAIL free_first: got %h want 11", free); end
        tick();
        checks++; if (free !== 5'h12 || cnt !== 4'd0) begin
            errors++; $display("FAIL free_second: got free=%h cnt=%0d want 12 0", free, cnt); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'b1111, 1'b0, 4'd0, 1'b0);
            tick();
        end
        drive(1'b1, 4'b0001, 1'b0, 4'd0, 1'b0);
        tick();
        for (int t = 1; t <= 13; t++) begin
            drive(1'b0, 4'b0000, 1'b1, 4'(t), 1'b0);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 4'b0000, 1'b0, 4'd0, 1'b0);
            tick();
        end
        drive(1'b1, 4'b1111, 1'b0, 4'd0, 1'b0);
        checks++; if (cnt !== 4'd0 || dis_mask[3:0] !== 4'd13) begin
            errors++; $display("FAIL wrap_pre: got cnt=%0d tail=%0d want 0 13", cnt, dis_mask[3:0]); end
        checks++; if (dis_tag !== 16'h10FE) begin errors++; $display("FAIL wrap_tags: got %h want 10fe", dis_tag); end
        tick();
        drive(1'b0, 4'b0000, 1'b1, 4'd0, 1'b1);
        tick();
        drive(1'b0, 4'b0000, 1'b0, 4'd0, 1'b0);
        checks++; if (kill !== 5'b1_1111) begin errors++; $display("FAIL wrap_kill: got %b want 11111", kill); end
        checks++; if (cnt !== 4'd2) begin errors++; $display("FAIL wrap_cnt: got %0d want 2", cnt); end
        tick();
        checks++; if (dis_mask[3:0] !== 4'd15) begin errors++; $display("FAIL wrap_tail: got %0d want 15", dis_mask[3:0]); end
    endtask

    task automatic test_reset_in_kill();
        do_reset();
        drive(1'b1, 4'b0111, 1'b0, 4'd0, 1'b0);
        tick();
        drive(1'b0, 4'b0000, 1'b1, 4'd3, 1'b1);
        tick();
        checks++; if (kill !== 5'h12) begin errors++; $display("FAIL rk_kill: got %h want 12", kill); end
        rst = 1'b1;
        drive(1'b0, 4'b0000, 1'b0, 4'd0, 1'b0);
        tick();
        rst = 1'b0;
        checks++; if (kill !== 5'd0 || cnt !== 4'd0 || dis_mask[3:0] !== 4'd0) begin
            errors++; $display("FAIL rk_reset: got kill=%h cnt=%0d tail=%0d want 0 0 0", kill, cnt, dis_mask[3:0]); end
        drive(1'b0, 4'b0000, 1'b1, 4'd3, 1'b0);
        tick();
        drive(1'b0, 4'b0000, 1'b0, 4'd0, 1'b0);
        tick();
        checks++; if (free !== 5'd0 || cnt !== 4'd0) begin
            errors++; $display("FAIL rk_stale: got free=%h cnt=%0d want 00 0", free, cnt); end
    endtask

    task automatic test_random();
        logic [3:0]  br;
        logic [3:0]  rt;
        logic [15:0] care;
        logic        we;
        logic        ren;
        logic        rm;
        int          idx;
        for (int c = 0; c < 600; c++) begin
            we  = ($urandom_range(0, 9) < 7);
            br  = 4'($urandom_range(0, 15));
            ren = ($urandom_range(0, 9) < 6);
            if (m_q.size() > 0 && $urandom_range(0, 9) < 8) begin
                idx = $urandom_range(0, m_q.size() - 1);
                rt  = 4'(m_q[idx]);
            end else begin
                rt = 4'($urandom_range(0, 15));
            end
            rm = ($urandom_range(0, 9) < 2);
            foreach (m_q[i]) if (m_q[i] == int'(rt) && m_d[i]) rm = 1'b0;
            rst = ($urandom_range(0, 199) == 0);
            drive(we, br, ren, rt, rm);
            care = '0;
            for (int k = 0; k < 4; k++) if (br[k]) care[k*4 +: 4] = 4'hF;
            checks++; if (dis_mask !== exp_masks(m_last, br)) begin
                errors++; $display("FAIL rnd_mask c=%0d: got %h want %h", c, dis_mask, exp_masks(m_last, br)); end
            checks++; if ((dis_tag & care) !== (exp_tags(m_last, br) & care)) begin
                errors++; $display("FAIL rnd_tag c=%0d: got %h want %h", c, dis_tag & care, exp_tags(m_last, br) & care); end
            checks++; if (stall !== (we && (m_kst || (ren && rm) || (m_q.size() + $countones(br) > 15)))) begin
                errors++; $display("FAIL rnd_stall c=%0d: got %b", c, stall); end
            tick();
            rst = 1'b0;
            checks++; if (kill !== m_kill) begin errors++; $display("FAIL rnd_kill c=%0d: got %h want %h", c, kill, m_kill); end
            checks++; if (free !== m_free) begin errors++; $display("FAIL rnd_free c=%0d: got %h want %h", c, free, m_free); end
            checks++; if (int'(cnt) !== m_q.size()) begin
                errors++; $display("FAIL rnd_cnt c=%0d: got %0d want %0d", c, cnt, m_q.size()); end
        end
    endtask

    initial begin
        test_reset();
        test_dispatch();
        test_full();
        test_mispredict();
        test_free_order();
        test_wrap();
        test_reset_in_kill();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
